adder_shift_unit: RTL and testbench

//   Registered integer datapath slice for the RISC-V ALU.
//   - Add/subtract unit with carry, overflow and X-vs-Y compare flags.
//   - Independent barrel shifter: left logical, right logical, right arithmetic.
//   - All results registered once. The ALU selects sum, shift result or compare flag per op.

---
 rtl/adder_shift_unit.sv | 121 ++++++++++++
 tb/tb_adder_shift_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder_shift_unit.sv
// Registered add/subtract, compare-flag and barrel-shift slice of the integer ALU.
// Every output is captured once per clock; there is no other internal state.
module adder_shift_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nadd_sub,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic            right_en,
  input  logic            sign,
  input  logic [XLEN-1:0] din,
  input  logic [5:0]      shift_n,
  output logic [XLEN-1:0] sum,
  output logic            carry,
  output logic            overflow,
  output logic            eq,
  output logic            lt,
  output logic            ltu,
  output logic [XLEN-1:0] sh_out
);

  localparam int unsigned MSB       = XLEN - 1;
  localparam int unsigned SH_STAGES = $clog2(XLEN);
  localparam int unsigned AMT_W     = (SH_STAGES > 6) ? SH_STAGES : 6;

  // ---------------------------------------------------------------------------
  // Adder: one carry chain, y conditionally inverted with nadd_sub as carry-in
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] y_eff_c;
  logic [XLEN:0]   sum_ext_c;
  logic            overflow_c;

  always_comb begin
    y_eff_c    = y ^ {XLEN{nadd_sub}};
    sum_ext_c  = {1'b0, x} + {1'b0, y_eff_c} + (XLEN+1)'(nadd_sub);
    overflow_c = (x[MSB] == y_eff_c[MSB]) && (sum_ext_c[MSB] != x[MSB]);
  end

  // ---------------------------------------------------------------------------
  // Compare flags: dedicated x - y path so flags never depend on nadd_sub
  // ---------------------------------------------------------------------------
  logic [XLEN:0] diff_ext_c;
  logic          diff_v_c;
  logic          eq_c;
  logic          lt_c;
  logic          ltu_c;

  always_comb begin
    diff_ext_c = {1'b0, x} + {1'b0, ~y} + (XLEN+1)'(1);
    diff_v_c   = (x[MSB] != y[MSB]) && (diff_ext_c[MSB] != x[MSB]);
    eq_c       = (diff_ext_c[MSB:0] == '0);
    ltu_c      = ~diff_ext_c[XLEN];
    lt_c       = diff_ext_c[MSB] ^ diff_v_c;
  end

  // ---------------------------------------------------------------------------
  // Barrel shifter: stage k moves by 2**k when amount bit k is set
  // ---------------------------------------------------------------------------
  logic [AMT_W-1:0] amt_c;
  logic             arith_c;
  logic             fill_c;
  logic             too_far_c;
  logic [XLEN-1:0]  stg_c [SH_STAGES+1];
  logic [XLEN-1:0]  sh_out_c;

  always_comb begin
    amt_c     = AMT_W'(shift_n);
    arith_c   = right_en & sign;
    fill_c    = arith_c & din[MSB];
    too_far_c = (32'(shift_n) >= XLEN);
  end

  assign stg_c[0] = din;

  for (genvar k = 0; k < SH_STAGES; k++) begin : g_stage
    localparam int unsigned DIST = 1 << k;
    logic [XLEN-1:0] shl_c;
    logic [XLEN-1:0] shr_c;

    always_comb begin
      shl_c = {stg_c[k][XLEN-DIST-1:0], {DIST{1'b0}}};
      shr_c = {{DIST{fill_c}}, stg_c[k][XLEN-1:DIST]};
    end

    assign stg_c[k+1] = !amt_c[k] ? stg_c[k] : (right_en ? shr_c : shl_c);
  end

  // Amounts of XLEN or more push every data bit out; only the fill remains
  always_comb begin
    sh_out_c = stg_c[SH_STAGES];
    if (too_far_c) begin
      sh_out_c = {XLEN{fill_c}};
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      eq       <= 1'b0;
      lt       <= 1'b0;
      ltu      <= 1'b0;
      sh_out   <= '0;
    end else begin
      sum      <= sum_ext_c[MSB:0];
      carry    <= sum_ext_c[XLEN];
      overflow <= overflow_c;
      eq       <= eq_c;
      lt       <= lt_c;
      ltu      <= ltu_c;
      sh_out   <= sh_out_c;
    end
  end

endmodule

// File: tb/tb_adder_shift_unit.sv
// Directed bench for adder_shift_unit: hand-computed vectors, immediate assertions.
module tb_adder_shift_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            nadd_sub;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;
  logic            right_en;
  logic            sign;
  logic [XLEN-1:0] din;
  logic [5:0]      shift_n;
  logic [XLEN-1:0] sum;
  logic            carry;
  logic            overflow;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic [XLEN-1:0] sh_out;

  int checks   = 0;
  int failures = 0;

  adder_shift_unit #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .nadd_sub (nadd_sub),
    .x        (x),
    .y        (y),
    .right_en (right_en),
    .sign     (sign),
    .din      (din),
    .shift_n  (shift_n),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow),
    .eq       (eq),
    .lt       (lt),
    .ltu      (ltu),
    .sh_out   (sh_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [XLEN-1:0] e_sum, input logic e_c,
                         input logic e_v, input logic e_eq, input logic e_lt, input logic e_ltu,
                         input logic [XLEN-1:0] e_sh);
    chk({tag, ".sum"},      sum,                 e_sum);
    chk({tag, ".carry"},    XLEN'(carry),        XLEN'(e_c));
    chk({tag, ".overflow"}, XLEN'(overflow),     XLEN'(e_v));
    chk({tag, ".eq"},       XLEN'(eq),           XLEN'(e_eq));
    chk({tag, ".lt"},       XLEN'(lt),           XLEN'(e_lt));
    chk({tag, ".ltu"},      XLEN'(ltu),          XLEN'(e_ltu));
    chk({tag, ".sh_out"},   sh_out,              e_sh);
  endtask

  // Drive one op on the falling edge so it is stable for the next rising edge
  task automatic drive(input logic ns, input logic [XLEN-1:0] xa, input logic [XLEN-1:0] yb,
                       input logic re, input logic sg, input logic [XLEN-1:0] d,
                       input logic [5:0] n);
    @(negedge clk);
    nadd_sub = ns;
    x        = xa;
    y        = yb;
    right_en = re;
    sign     = sg;
    din      = d;
    shift_n  = n;
  endtask

  task automatic capture();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    nadd_sub = 1'b0;
    x        = '0;
    y        = '0;
    right_en = 1'b0;
    sign     = 1'b0;
    din      = '0;
    shift_n  = '0;

    #3;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // add wrap: -1 + 1; left shift by 4
    drive(1'b0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0001, 6'd4);
    capture();
    chk_all("add_wrap", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010);

    // positive overflow; right logical by 4; result must not appear before the edge
    drive(1'b0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0, 32'h8000_0001, 6'd4);
    #1;
    chk("latency_hold.sum", sum, 32'h0);
    capture();
    chk_all("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0800_0000);

    // 5 - 7 with borrow; right arithmetic by 4
    drive(1'b1, 32'h5, 32'h7, 1'b1, 1'b1, 32'h8000_0001, 6'd4);
    capture();
    chk_all("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hF800_0000);

    // asynchronous reset between edges with nonzero inputs and outputs
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    capture();
    chk_all("rst_held_edge", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // signed vs unsigned compare; left shift by 32
    drive(1'b0, 32'h8000_0000, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 6'd32);
    capture();
    chk_all("cmp_signed", 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

    // equal operands with add; right logical by 32
    drive(1'b0, 32'h1234, 32'h1234, 1'b1, 1'b0, 32'h8000_0000, 6'd32);
    capture();
    chk_all("add_eq", 32'h2468, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // subtract negative overflow; right arithmetic by 32
    drive(1'b1, 32'h8000_0000, 32'h1, 1'b1, 1'b1, 32'h8000_0000, 6'd32);
    capture();
    chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);

    // back-to-back ops on consecutive edges, each checked one cycle after its inputs
    drive(1'b1, 32'h1234, 32'h1234, 1'b1, 1'b1, 32'hA5A5_5A5A, 6'd0);
    capture();
    chk_all("sub_eq_sh0", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A);

    drive(1'b1, 32'h0, 32'h0, 1'b1, 1'b1, 32'h8000_0000, 6'd31);
    capture();
    chk_all("sra31", 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // sign ignored for left shifts; amount 63 clears
    drive(1'b0, 32'h3, 32'h9, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'd63);
    capture();
    chk_all("sll63", 32'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);

    drive(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 6'd1);
    capture();
    chk_all("sll1", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);

    // arithmetic right with positive data fills zeros; 17-bit amount crosses stages
    drive(1'b1, 32'h10, 32'hFFFF_FFF0, 1'b1, 1'b1, 32'h4321_8765, 6'd17);
    capture();
    chk_all("sra17_pos", 32'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2190);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute safety bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
